// File: rtl/red_pitaya_lock_ctrl.sv
// Lock controller for a Red Pitaya PID loop: sweeps an offset until the
// monitor signal enters a window, lets the PID settle, watches for loss of
// lock and optionally relocks.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | disabled, sweep parked at minimum, PID integrator held reset
// SWEEP   | offset scanning between min/max, waiting for in-window signal
// ACQUIRE | PID running, counting consecutive in-window cycles
// LOCKED  | lock declared, counting consecutive fault cycles
// LOST    | PID output held, waiting for relock enable or disable
module red_pitaya_lock_ctrl #(
   parameter int CNT_BITS = 32,
   parameter int RC_BITS  = 16
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       en_i,
   input  logic                       relock_en_i,
   input  logic signed [13:0]         dat_i,
   input  logic signed [13:0]         set_thr_lo_i,
   input  logic signed [13:0]         set_thr_hi_i,
   input  logic signed [13:0]         set_sweep_min_i,
   input  logic signed [13:0]         set_sweep_max_i,
   input  logic        [12:0]         set_sweep_step_i,
   input  logic        [CNT_BITS-1:0] set_sweep_div_i,
   input  logic        [CNT_BITS-1:0] set_settle_i,
   input  logic        [CNT_BITS-1:0] set_lost_i,
   input  logic        [1:0]          railed_i,
   output logic signed [13:0]         sweep_o,
   output logic signed [13:0]         int_ctr_val_o,
   output logic                       pid_int_rst_o,
   output logic                       pid_int_ctr_rst_o,
   output logic                       pid_hold_o,
   output logic                       pid_en_o,
   output logic        [2:0]          state_o,
   output logic                       locked_o,
   output logic        [RC_BITS-1:0]  relock_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SWEEP   = 3'd1,
      S_ACQUIRE = 3'd2,
      S_LOCKED  = 3'd3,
      S_LOST    = 3'd4
   } state_t;

   localparam logic [CNT_BITS-1:0] CNT_ONE = 1;
   localparam logic [RC_BITS-1:0]  RC_ONE  = 1;

   state_t              state_q, state_d;
   logic [CNT_BITS-1:0] div_q, settle_q, loss_q;
   logic                dir_down_q;
   logic                in_win, fault, sweep_ok;
   logic                int_rst_d, hold_d, en_d, locked_d;
   logic signed [14:0]  cur_x, min_x, max_x, step_x, up_x, dn_x;

   assign in_win   = (dat_i >= set_thr_lo_i) && (dat_i <= set_thr_hi_i);
   assign fault    = !in_win || (|railed_i);
   assign sweep_ok = (set_sweep_min_i <= set_sweep_max_i) && (|set_sweep_step_i);
   assign state_o  = state_q;

   // 15-bit sweep arithmetic so a step can never wrap the 14-bit offset
   assign cur_x  = {sweep_o[13], sweep_o};
   assign min_x  = {set_sweep_min_i[13], set_sweep_min_i};
   assign max_x  = {set_sweep_max_i[13], set_sweep_max_i};
   assign step_x = {2'b00, set_sweep_step_i};
   assign up_x   = cur_x + step_x;
   assign dn_x   = cur_x - step_x;

   // state register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // next-state logic; threshold compares use the registered counts
   always_comb begin
      state_d = S_IDLE;
      if (en_i) begin
         case (state_q)
            S_IDLE:    state_d = S_SWEEP;
            S_SWEEP:   state_d = in_win ? S_ACQUIRE : S_SWEEP;
            S_ACQUIRE: begin
               if (settle_q >= set_settle_i) state_d = S_LOCKED;
               else if (!in_win)             state_d = S_SWEEP;
               else                          state_d = S_ACQUIRE;
            end
            S_LOCKED:  state_d = (loss_q >= set_lost_i) ? S_LOST : S_LOCKED;
            S_LOST:    state_d = relock_en_i ? S_SWEEP : S_LOST;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // output decode of the state being entered, registered below
   always_comb begin
      int_rst_d = (state_d == S_IDLE) || (state_d == S_SWEEP);
      en_d      = (state_d == S_ACQUIRE) || (state_d == S_LOCKED) || (state_d == S_LOST);
      hold_d    = (state_d == S_LOST);
      locked_d  = (state_d == S_LOCKED);
   end

   // registered outputs, sweep generator and counters
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pid_int_rst_o     <= 1'b1;
         pid_int_ctr_rst_o <= 1'b0;
         pid_hold_o        <= 1'b0;
         pid_en_o          <= 1'b0;
         locked_o          <= 1'b0;
         sweep_o           <= '0;
         int_ctr_val_o     <= '0;
         dir_down_q        <= 1'b0;
         div_q             <= '0;
         settle_q          <= '0;
         loss_q            <= '0;
         relock_cnt_o      <= '0;
      end else begin
         pid_int_rst_o     <= int_rst_d;
         pid_hold_o        <= hold_d;
         pid_en_o          <= en_d;
         locked_o          <= locked_d;
         pid_int_ctr_rst_o <= (state_q == S_SWEEP) && (state_d == S_ACQUIRE);

         if ((state_q == S_SWEEP) && (state_d == S_ACQUIRE))
            int_ctr_val_o <= sweep_o;

         if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
            sweep_o    <= set_sweep_min_i;
            dir_down_q <= 1'b0;
            div_q      <= '0;
         end else if ((state_q == S_SWEEP) && (state_d == S_SWEEP)) begin
            if (div_q >= set_sweep_div_i) begin
               div_q <= '0;
               if (sweep_ok) begin
                  if (!dir_down_q) begin
                     if (up_x >= max_x) begin
                        sweep_o    <= set_sweep_max_i;
                        dir_down_q <= 1'b1;
                     end else begin
                        sweep_o <= up_x[13:0];
                     end
                  end else begin
                     if (dn_x <= min_x) begin
                        sweep_o    <= set_sweep_min_i;
                        dir_down_q <= 1'b0;
                     end else begin
                        sweep_o <= dn_x[13:0];
                     end
                  end
               end
            end else begin
               div_q <= div_q + CNT_ONE;
            end
         end else if (state_d == S_SWEEP) begin
            div_q <= '0;
         end

         if (state_d != state_q) begin
            settle_q <= '0;
            loss_q   <= '0;
         end else if (state_q == S_ACQUIRE) begin
            if (settle_q != '1) settle_q <= settle_q + CNT_ONE;
         end else if (state_q == S_LOCKED) begin
            if (!fault)          loss_q <= '0;
            else if (loss_q != '1) loss_q <= loss_q + CNT_ONE;
         end

         if ((state_q == S_LOST) && (state_d == S_SWEEP) && (relock_cnt_o != '1))
            relock_cnt_o <= relock_cnt_o + RC_ONE;
      end
   end

endmodule

// File: tb/tb_red_pitaya_lock_ctrl.sv
// Bench for red_pitaya_lock_ctrl: directed lock/loss/relock scenarios plus
// randomized configurations, every cycle compared against a reference model.
module tb_red_pitaya_lock_ctrl;

   localparam int RC_BITS = 3;
   localparam int RC_MAX  = 7;
   localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

   logic               clk = 1'b0;
   logic               rstn, en, relock_en;
   logic signed [13:0] dat, thr_lo, thr_hi, smin, smax;
   logic        [12:0] step;
   logic        [31:0] sdiv, settle, lost;
   logic        [1:0]  railed;
   logic signed [13:0] sweep_o, int_ctr_val_o;
   logic               pid_int_rst_o, pid_int_ctr_rst_o, pid_hold_o, pid_en_o, locked_o;
   logic        [2:0]  state_o;
   logic [RC_BITS-1:0] relock_cnt_o;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state (states by number: 0 idle .. 4 lost)
   int     m_st, m_sweep, m_ictr, m_relock;
   bit     m_down, m_pulse;
   longint m_div, m_settle, m_loss;

   red_pitaya_lock_ctrl #(.CNT_BITS(32), .RC_BITS(RC_BITS)) dut (
      .clk_i(clk), .rstn_i(rstn), .en_i(en), .relock_en_i(relock_en),
      .dat_i(dat), .set_thr_lo_i(thr_lo), .set_thr_hi_i(thr_hi),
      .set_sweep_min_i(smin), .set_sweep_max_i(smax), .set_sweep_step_i(step),
      .set_sweep_div_i(sdiv), .set_settle_i(settle), .set_lost_i(lost),
      .railed_i(railed), .sweep_o(sweep_o), .int_ctr_val_o(int_ctr_val_o),
      .pid_int_rst_o(pid_int_rst_o), .pid_int_ctr_rst_o(pid_int_ctr_rst_o),
      .pid_hold_o(pid_hold_o), .pid_en_o(pid_en_o), .state_o(state_o),
      .locked_o(locked_o), .relock_cnt_o(relock_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_sweep = 0; m_ictr = 0; m_relock = 0;
      m_down = 0; m_pulse = 0; m_div = 0; m_settle = 0; m_loss = 0;
   endtask

   // one clock of behaviour, computed from the current inputs
   task automatic model_step();
      int  lo, hi, d, mn, mx, stp, ns, r;
      bit  win, bad;
      lo = int'(thr_lo); hi = int'(thr_hi); d = int'(dat);
      mn = int'(smin);   mx = int'(smax);   stp = int'(step);
      win = (d >= lo) && (d <= hi);
      bad = !win || (railed != 2'b00);
      if (!en) ns = 0;
      else if (m_st == 0) ns = 1;
      else if (m_st == 1) ns = win ? 2 : 1;
      else if (m_st == 2) ns = (m_settle >= longint'(settle)) ? 3 : (win ? 2 : 1);
      else if (m_st == 3) ns = (m_loss >= longint'(lost)) ? 4 : 3;
      else                ns = relock_en ? 1 : 4;

      m_pulse = (m_st == 1) && (ns == 2);
      if (m_pulse) m_ictr = m_sweep;

      if (m_st == 0 || ns == 0) begin
         m_sweep = mn; m_down = 0; m_div = 0;
      end else if (m_st == 1 && ns == 1) begin
         if (m_div >= longint'(sdiv)) begin
            m_div = 0;
            if (mn <= mx && stp != 0) begin
               r = m_down ? m_sweep - stp : m_sweep + stp;
               if (!m_down && r >= mx)     begin m_sweep = mx; m_down = 1; end
               else if (m_down && r <= mn) begin m_sweep = mn; m_down = 0; end
               else m_sweep = r;
            end
         end else m_div++;
      end else if (ns == 1) m_div = 0;

      if (ns != m_st) begin m_settle = 0; m_loss = 0; end
      else if (m_st == 2) m_settle = (m_settle < CNT_MAX) ? m_settle + 1 : m_settle;
      else if (m_st == 3) m_loss = !bad ? 0 : ((m_loss < CNT_MAX) ? m_loss + 1 : m_loss);

      if (m_st == 4 && ns == 1 && m_relock < RC_MAX) m_relock++;
      m_st = ns;
   endtask

   task automatic check_all();
      chk("state",       state_o,           m_st);
      chk("sweep",       sweep_o,           m_sweep);
      chk("int_ctr_val", int_ctr_val_o,     m_ictr);
      chk("int_ctr_rst", pid_int_ctr_rst_o, m_pulse);
      chk("int_rst",     pid_int_rst_o,     (m_st <= 1));
      chk("pid_en",      pid_en_o,          (m_st >= 2 && m_st <= 4));
      chk("hold",        pid_hold_o,        (m_st == 4));
      chk("locked",      locked_o,          (m_st == 3));
      chk("relock_cnt",  relock_cnt_o,      m_relock);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic wait_state(input string tag, input int target, input int budget);
      int n = 0;
      while (int'(state_o) != target && n < budget) begin
         tick();
         n++;
      end
      chk(tag, state_o, target);
   endtask

   int exp_seq [7] = '{-100, -50, 0, 50, 100, 50, 0};

   initial begin
      int lo, hi, mn;
      rstn = 1'b0; en = 1'b0; relock_en = 1'b0; dat = '0; railed = '0;
      thr_lo = 14'sd1000; thr_hi = 14'sd2000; smin = -14'sd100; smax = 14'sd100;
      step = 13'd50; sdiv = 32'd1; settle = 32'd10; lost = 32'd4;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rstn = 1'b1; en = 1'b1; relock_en = 1'b1;

      // triangular sweep, one change every two clocks
      for (int k = 0; k < 13; k++) begin
         tick();
         if (k % 2 == 0) chk("sweep_seq", sweep_o, exp_seq[k / 2]);
      end

      // signal enters the window at sweep 0
      dat = 14'sd1500;
      tick();
      chk("acq_entry", state_o, 2);
      chk("acq_ictr", int_ctr_val_o, 0);
      chk("acq_pulse", pid_int_ctr_rst_o, 1);
      tick();
      chk("acq_pulse_end", pid_int_ctr_rst_o, 0);
      repeat (3) tick();
      dat = 14'sd0;
      tick();
      chk("acq_abort", state_o, 1);
      chk("acq_abort_sweep", sweep_o, 0);
      repeat (4) tick();

      // settle: ten more in-window cycles stay ACQUIRE, the eleventh locks
      dat = 14'sd1500;
      tick();
      chk("acq_entry2", state_o, 2);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("settling", state_o, 2);
      end
      tick();
      chk("locked", state_o, 3);

      // railed for 3 cycles is tolerated, 4 cycles loses lock
      railed = 2'b10;
      repeat (3) tick();
      railed = 2'b00;
      repeat (3) begin
         tick();
         chk("rail3_locked", state_o, 3);
      end
      railed = 2'b10;
      repeat (4) tick();
      railed = 2'b00;
      tick();
      chk("lost", state_o, 4);
      chk("lost_hold", pid_hold_o, 1);
      tick();
      chk("relock", state_o, 1);
      chk("relock_cnt", relock_cnt_o, 1);

      // without relock the controller parks in LOST until disabled
      relock_en = 1'b0;
      wait_state("wait_locked", 3, 40);
      railed = 2'b01;
      wait_state("wait_lost", 4, 20);
      railed = 2'b00;
      repeat (5) begin
         tick();
         chk("park_lost", state_o, 4);
      end
      en = 1'b0;
      tick();
      chk("disable_idle", state_o, 0);
      chk("disable_sweep", sweep_o, -100);

      // asynchronous reset between edges while sweeping
      en = 1'b1; dat = 14'sd0;
      repeat (6) tick();
      #2;
      rstn = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rstn = 1'b1;
      tick();
      chk("post_reset_sweep", sweep_o, -100);

      // randomized configurations
      for (int ep = 0; ep < 25; ep++) begin
         mn = $urandom_range(0, 400) - 200;
         smin = 14'(mn);
         smax = 14'(mn + int'($urandom_range(0, 500)) - 60);
         step = ($urandom_range(0, 4) == 0) ? 13'd0 : 13'($urandom_range(1, 120));
         sdiv = $urandom_range(0, 3);
         settle = $urandom_range(0, 6);
         lost = $urandom_range(0, 5);
         lo = $urandom_range(0, 400) - 200;
         hi = lo + int'($urandom_range(0, 300)) - 30;
         thr_lo = 14'(lo); thr_hi = 14'(hi);
         relock_en = 1'($urandom_range(0, 1));
         for (int c = 0; c < 150; c++) begin
            en = ($urandom_range(0, 49) != 0);
            railed = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (hi >= lo && $urandom_range(0, 9) < 7)
               dat = 14'(lo + int'($urandom_range(0, hi - lo)));
            else
               dat = 14'(int'($urandom_range(0, 1000)) - 500);
            tick();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
